constant_encoder: RTL and testbench

CONSTANT_ENCODER -- requirements
Module: constant_encoder

---
 rtl/constant_encoder.sv | 97 +++++++++
 tb/tb_constant_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/constant_encoder.sv
// Constant-table encoder: maps an operand onto a 3-bit small-constant code.
// Ports: clk, rst_n (sync, active-low), req_* in handshake, rsp_* out handshake, busy.
module constant_encoder #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_value,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [2:0]           rsp_code,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  logic [2:0]           idx;
  logic [WORD_SIZE-1:0] operand;
  logic                 hit_q;
  logic [2:0]           code_q;
  logic [WORD_SIZE-1:0] entry;

  // Table entry at the scan index; code 7 is all-ones at full width.
  always_comb begin
    entry = '0;
    unique case (idx)
      3'd0: entry = WORD_SIZE'(0);
      3'd1: entry = WORD_SIZE'(1);
      3'd2: entry = WORD_SIZE'(2);
      3'd3: entry = WORD_SIZE'(4);
      3'd4: entry = WORD_SIZE'(8);
      3'd5: entry = WORD_SIZE'(32);
      3'd6: entry = WORD_SIZE'(48);
      3'd7: entry = '1;
      default: entry = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 3'd0;
      operand <= '0;
      hit_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            operand <= req_value;
            idx     <= 3'd0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          // Scan upward so the lowest matching code wins.
          if (operand == entry) begin
            hit_q  <= 1'b1;
            code_q <= idx;
            state  <= RESP;
          end else if (idx == 3'd7) begin
            hit_q  <= 1'b0;
            code_q <= 3'd0;
            state  <= RESP;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            hit_q  <= 1'b0;
            code_q <= 3'd0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_hit   = hit_q;
  assign rsp_code  = code_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_constant_encoder.sv
// Directed bench for constant_encoder (WORD_SIZE=16).
// Latency counted with the cycle after the accepting edge as cycle 1.
module tb_constant_encoder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_value;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [2:0]  rsp_code;
  logic        busy;

  int checks;
  int errors;

  constant_encoder #(.WORD_SIZE(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_value(req_value),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit),
    .rsp_code(rsp_code),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request, then count cycles until rsp_valid.
  task automatic run_req(input string tag, input logic [15:0] v,
                         input logic rr, input int exp_hit,
                         input int exp_code, input int exp_lat);
    int lat;
    req_valid = 1'b1;
    req_value = v;
    rsp_ready = rr;
    tick();
    req_valid = 1'b0;
    req_value = ~v;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " hit"}, int'(rsp_hit), exp_hit);
    check({tag, " code"}, int'(rsp_code), exp_code);
    check({tag, " req_ready in RESP"}, int'(req_ready), 0);
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_value = 16'h0004;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("reset req_ready", int'(req_ready), 1);
    check("reset rsp_valid", int'(rsp_valid), 0);
    check("reset rsp_hit", int'(rsp_hit), 0);
    check("reset rsp_code", int'(rsp_code), 0);
    check("reset busy", int'(busy), 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle after reset busy", int'(busy), 0);

    run_req("v0004", 16'h0004, 1'b1, 1, 3, 5);
    tick();
    check("v0004 back to idle", int'(req_ready), 1);
    check("v0004 rsp_valid drop", int'(rsp_valid), 0);
    check("v0004 code cleared", int'(rsp_code), 0);

    run_req("vFFFF", 16'hFFFF, 1'b1, 1, 7, 9);
    tick();
    check("vFFFF back to idle", int'(busy), 0);

    run_req("v0010", 16'h0010, 1'b1, 0, 0, 9);
    tick();
    check("v0010 back to idle", int'(req_ready), 1);

    run_req("v0008", 16'h0008, 1'b1, 1, 4, 6);
    tick();

    // Held response with rsp_ready low for five cycles.
    run_req("v0030", 16'h0030, 1'b0, 1, 6, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold rsp_valid", int'(rsp_valid), 1);
      check("hold hit", int'(rsp_hit), 1);
      check("hold code", int'(rsp_code), 6);
      check("hold req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("hold released idle", int'(req_ready), 1);
    check("hold released rsp_valid", int'(rsp_valid), 0);

    // Code 0, then a back-to-back request with req_valid held high.
    req_valid = 1'b1;
    req_value = 16'h0000;
    rsp_ready = 1'b1;
    tick();
    check("b2b accept busy", int'(busy), 1);
    req_value = 16'h0001;
    tick();
    check("b2b first rsp_valid", int'(rsp_valid), 1);
    check("b2b first hit", int'(rsp_hit), 1);
    check("b2b first code", int'(rsp_code), 0);
    tick();
    check("b2b not taken in RESP", int'(req_ready), 1);
    check("b2b idle rsp_valid", int'(rsp_valid), 0);
    tick();
    check("b2b second accept busy", int'(busy), 1);
    req_valid = 1'b0;
    tick();
    check("b2b second scan rsp_valid", int'(rsp_valid), 0);
    tick();
    check("b2b second rsp_valid", int'(rsp_valid), 1);
    check("b2b second hit", int'(rsp_hit), 1);
    check("b2b second code", int'(rsp_code), 1);
    tick();
    check("b2b second done", int'(req_ready), 1);

    // Reset during SCAN aborts the lookup.
    req_valid = 1'b1;
    req_value = 16'h0020;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("abort in scan", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort idle req_ready", int'(req_ready), 1);
    check("abort rsp_valid", int'(rsp_valid), 0);
    check("abort busy", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("abort no response", seen, 0);
    check("abort still idle", int'(req_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
